// File: rtl/axil_cfg_master.sv
// axil_cfg_master: turns one-at-a-time register commands into single AXI4-Lite transactions.
// Optional per-transaction timeout abort is built in when AXIL_TIMEOUT_EN is defined.
module axil_cfg_master #(
    parameter int G_ADDR_W = 12,
    parameter int G_DATA_B = 4,
    parameter int G_DATA_W = G_DATA_B << 3
`ifdef AXIL_TIMEOUT_EN
    ,
    parameter int G_TOUT   = 1023
`endif
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_vld,
    output logic                o_cmd_rdy,
    input  logic                i_cmd_wr,
    input  logic [G_ADDR_W-1:0] i_cmd_addr,
    input  logic [G_DATA_W-1:0] i_cmd_data,
    input  logic [G_DATA_B-1:0] i_cmd_strb,
    output logic                o_rsp_vld,
    input  logic                i_rsp_rdy,
    output logic [G_DATA_W-1:0] o_rsp_data,
    output logic [1:0]          o_rsp_resp,
    output logic                o_rsp_tout,
    output logic [G_ADDR_W-1:0] m_axil_awaddr,
    output logic [2:0]          m_axil_awprot,
    output logic                m_axil_awvalid,
    input  logic                m_axil_awready,
    output logic [G_DATA_W-1:0] m_axil_wdata,
    output logic [G_DATA_B-1:0] m_axil_wstrb,
    output logic                m_axil_wvalid,
    input  logic                m_axil_wready,
    input  logic [1:0]          m_axil_bresp,
    input  logic                m_axil_bvalid,
    output logic                m_axil_bready,
    output logic [G_ADDR_W-1:0] m_axil_araddr,
    output logic [2:0]          m_axil_arprot,
    output logic                m_axil_arvalid,
    input  logic                m_axil_arready,
    input  logic [G_DATA_W-1:0] m_axil_rdata,
    input  logic [1:0]          m_axil_rresp,
    input  logic                m_axil_rvalid,
    output logic                m_axil_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_AW,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_RSP
    } state_t;

    state_t                state_q;
    logic                  cmd_rdy_q;
    logic [G_ADDR_W-1:0]   addr_q;
    logic [G_DATA_W-1:0]   data_q;
    logic [G_DATA_B-1:0]   strb_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic                  rsp_vld_q;
    logic [G_DATA_W-1:0]   rsp_data_q;
    logic [1:0]            rsp_resp_q;
    logic                  aw_done_d;
    logic                  w_done_d;
    logic                  accept;

    assign accept = i_cmd_vld & cmd_rdy_q;

    // AW and W complete independently; a channel counts as done from its handshake cycle on.
    always_comb begin
        aw_done_d = aw_done_q | (awvalid_q & m_axil_awready);
        w_done_d  = w_done_q  | (wvalid_q  & m_axil_wready);
    end

`ifdef AXIL_TIMEOUT_EN
    logic [15:0] tout_cnt_q;
    logic        rsp_tout_q;
    logic        busy;
    logic        tout_hit;

    assign busy     = (state_q == S_WR_AW) || (state_q == S_WR_B) ||
                      (state_q == S_RD_AR) || (state_q == S_RD_R);
    // Abort on the edge where the count would reach G_TOUT, so valids last exactly G_TOUT cycles.
    assign tout_hit = busy && ((tout_cnt_q + 16'd1) == 16'(G_TOUT));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tout_cnt_q <= '0;
            rsp_tout_q <= 1'b0;
        end else if (accept) begin
            tout_cnt_q <= '0;
            rsp_tout_q <= 1'b0;
        end else begin
            if (busy) begin
                tout_cnt_q <= tout_cnt_q + 16'd1;
            end
            if (tout_hit) begin
                rsp_tout_q <= 1'b1;
            end
        end
    end

    assign o_rsp_tout = rsp_tout_q;
`else
    assign o_rsp_tout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cmd_rdy_q  <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_resp_q <= 2'b00;
        end else begin
`ifdef AXIL_TIMEOUT_EN
            if (tout_hit) begin
                awvalid_q  <= 1'b0;
                wvalid_q   <= 1'b0;
                arvalid_q  <= 1'b0;
                bready_q   <= 1'b0;
                rready_q   <= 1'b0;
                rsp_vld_q  <= 1'b1;
                rsp_data_q <= '0;
                rsp_resp_q <= 2'b10;
                state_q    <= S_RSP;
            end else
`endif
            begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            cmd_rdy_q <= 1'b0;
                            addr_q    <= i_cmd_addr;
                            data_q    <= i_cmd_data;
                            strb_q    <= i_cmd_strb;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            if (i_cmd_wr) begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= S_WR_AW;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= S_RD_AR;
                            end
                        end
                    end
                    S_WR_AW: begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                        if (awvalid_q && m_axil_awready) begin
                            awvalid_q <= 1'b0;
                        end
                        if (wvalid_q && m_axil_wready) begin
                            wvalid_q <= 1'b0;
                        end
                        if (aw_done_d && w_done_d) begin
                            bready_q <= 1'b1;
                            state_q  <= S_WR_B;
                        end
                    end
                    S_WR_B: begin
                        if (m_axil_bvalid && bready_q) begin
                            bready_q   <= 1'b0;
                            rsp_vld_q  <= 1'b1;
                            rsp_data_q <= '0;
                            rsp_resp_q <= m_axil_bresp;
                            state_q    <= S_RSP;
                        end
                    end
                    S_RD_AR: begin
                        if (m_axil_arready) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state_q   <= S_RD_R;
                        end
                    end
                    S_RD_R: begin
                        if (m_axil_rvalid && rready_q) begin
                            rready_q   <= 1'b0;
                            rsp_vld_q  <= 1'b1;
                            rsp_data_q <= m_axil_rdata;
                            rsp_resp_q <= m_axil_rresp;
                            state_q    <= S_RSP;
                        end
                    end
                    S_RSP: begin
                        if (i_rsp_rdy) begin
                            rsp_vld_q <= 1'b0;
                            cmd_rdy_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_cmd_rdy      = cmd_rdy_q;
    assign o_rsp_vld      = rsp_vld_q;
    assign o_rsp_data     = rsp_data_q;
    assign o_rsp_resp     = rsp_resp_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = data_q;
    assign m_axil_wstrb   = strb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master against a small registered AXI4-Lite responder model.
// The responder raises each ready (wait+1) cycles after seeing valid and answers B/R one cycle after.
module tb_axil_cfg_master;

    logic        clk;
    logic        rst;
    logic        cmd_vld, cmd_rdy, cmd_wr;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_strb;
    logic        rsp_vld, rsp_rdy, rsp_tout;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [11:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_chk  = 0;
    int n_pass = 0;

    axil_cfg_master #(
        .G_ADDR_W(12),
        .G_DATA_B(4)
`ifdef AXIL_TIMEOUT_EN
        ,
        .G_TOUT(16)
`endif
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_vld(cmd_vld), .o_cmd_rdy(cmd_rdy), .i_cmd_wr(cmd_wr),
        .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_strb(cmd_strb),
        .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy), .o_rsp_data(rsp_data),
        .o_rsp_resp(rsp_resp), .o_rsp_tout(rsp_tout),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- responder model ----------------
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit          ar_never = 0, b_hold = 0;
    logic [1:0]  sl_bresp = 2'b00, sl_rresp = 2'b00;
    logic [31:0] sl_rdata = '0;
    int          aw_c, w_c, ar_c;
    logic        aw_got, w_got;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic [11:0] sl_awaddr, sl_araddr;
    logic [31:0] sl_wdata;
    logic [3:0]  sl_wstrb;
    logic        aw_fire, w_fire, ar_fire;

    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign ar_fire = arvalid & arready;

    always @(posedge clk) begin
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            bvalid  <= 1'b0; rvalid <= 1'b0;
            bresp   <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_c <= 0; w_c <= 0; ar_c <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (aw_fire) begin
                awready <= 1'b0; aw_c <= 0; aw_hs <= aw_hs + 1; sl_awaddr <= awaddr;
            end else if (awvalid && !awready) begin
                if (aw_c >= aw_wait) awready <= 1'b1; else aw_c <= aw_c + 1;
            end
            if (w_fire) begin
                wready <= 1'b0; w_c <= 0; w_hs <= w_hs + 1; sl_wdata <= wdata; sl_wstrb <= wstrb;
            end else if (wvalid && !wready) begin
                if (w_c >= w_wait) wready <= 1'b1; else w_c <= w_c + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; b_hs <= b_hs + 1;
            end else if ((aw_got || aw_fire) && (w_got || w_fire) && !b_hold && !bvalid) begin
                bvalid <= 1'b1; bresp <= sl_bresp; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_fire) aw_got <= 1'b1;
                if (w_fire)  w_got  <= 1'b1;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; r_hs <= r_hs + 1;
            end
            if (ar_fire) begin
                arready <= 1'b0; ar_c <= 0; ar_hs <= ar_hs + 1; sl_araddr <= araddr;
                rvalid <= 1'b1; rdata <= sl_rdata; rresp <= sl_rresp;
            end else if (arvalid && !arready && !ar_never) begin
                if (ar_c >= ar_wait) arready <= 1'b1; else ar_c <= ar_c + 1;
            end
        end
    end

    // ---------------- valid-stability monitor ----------------
    bit          mon_en = 0;
    int          viol = 0;
    logic        p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0;
    logic [11:0] p_awaddr = '0, p_araddr = '0;
    logic [31:0] p_wdata = '0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            viol <= viol
                  + int'(p_aw && !p_awr && (!awvalid || awaddr != p_awaddr))
                  + int'(p_w  && !p_wr  && (!wvalid  || wdata  != p_wdata))
                  + int'(p_ar && !p_arr && (!arvalid || araddr != p_araddr));
        end
        p_aw <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
        p_w  <= wvalid;  p_wr  <= wready;  p_wdata  <= wdata;
        p_ar <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_wr = wr; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_vld = 1'b1;
        chk("cmd_rdy_at_accept", cmd_rdy, 1);
        tick();
        cmd_vld = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accepting edge.
    task automatic wait_rsp(input int start, output int lat);
        lat = start;
        while (!rsp_vld && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat;
    int b0, aw0, w0;

    initial begin
        rst = 1'b1; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_strb = '0; rsp_rdy = 1'b0;
        tick(); tick(); tick();
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rst_rsp", {rsp_vld, rsp_tout, rsp_resp}, 4'b0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_addr_data", {awaddr, wdata, wstrb}, 48'h0);
        rst = 1'b0;
        tick();
        mon_en = 1;

        // 1: zero-wait write
        issue(1'b1, 12'h004, 32'hDEADBEEF, 4'hF);
        chk("t1_aw_w_valid", {awvalid, wvalid, awprot}, 5'b11000);
        wait_rsp(1, lat);
        chk("t1_latency", lat, 4);
        chk("t1_resp", rsp_resp, 2'b00);
        chk("t1_data", rsp_data, 0);
        chk("t1_tout", rsp_tout, 0);
        chk("t1_awaddr", sl_awaddr, 12'h004);
        chk("t1_wdata", sl_wdata, 32'hDEADBEEF);
        chk("t1_wstrb", sl_wstrb, 4'hF);
        chk("t1_beats", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, 24'h010101);
        release_rsp();
        chk("t1_idle_rdy", {rsp_vld, cmd_rdy}, 2'b01);
        $display("t1 write 0x004 latency=%0d resp=%0d", lat, rsp_resp);

        // 2: read with arready delayed by 5 wait cycles
        ar_wait = 5; sl_rdata = 32'h12345678; sl_rresp = 2'b00;
        issue(1'b0, 12'h008, 32'h0, 4'h0);
        wait_rsp(1, lat);
        chk("t2_latency", lat, 9);
        chk("t2_data", rsp_data, 32'h12345678);
        chk("t2_resp", {rsp_resp, rsp_tout}, 3'b000);
        chk("t2_araddr", {sl_araddr, arprot}, {12'h008, 3'b000});
        chk("t2_ar_beats", ar_hs, 1);
        release_rsp();
        ar_wait = 0;
        $display("t2 read 0x008 latency=%0d data=0x%08h", lat, rsp_data);

        // 3: awready three cycles ahead of wready, SLVERR response
        w_wait = 3; sl_bresp = 2'b10;
        b0 = b_hs; aw0 = aw_hs; w0 = w_hs;
        issue(1'b1, 12'h0A0, 32'h0BADF00D, 4'h3);
        tick(); tick();
        chk("t3_aw_dropped", {awvalid, wvalid}, 2'b01);
        tick(); tick();
        chk("t3_w_held", {wvalid, wready}, 2'b11);
        wait_rsp(5, lat);
        chk("t3_latency", lat, 7);
        chk("t3_resp", rsp_resp, 2'b10);
        chk("t3_wdata", {sl_wdata, sl_wstrb}, {32'h0BADF00D, 4'h3});
        release_rsp();
        tick(); tick();
        chk("t3_one_b", b_hs - b0, 1);
        chk("t3_one_aw_w", {aw_hs - aw0, w_hs - w0}, {32'd1, 32'd1});
        w_wait = 0; sl_bresp = 2'b00;
        $display("t3 write 0x0A0 latency=%0d resp=%0d", lat, rsp_resp);

        // 4: response back-pressure with a competing command
        sl_rdata = 32'hCAFEF00D;
        aw0 = aw_hs;
        issue(1'b0, 12'h00C, 32'h0, 4'h0);
        wait_rsp(1, lat);
        chk("t4_latency", lat, 4);
        cmd_wr = 1'b1; cmd_addr = 12'h100; cmd_data = 32'h11111111; cmd_strb = 4'hF; cmd_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_vld_rdy", {rsp_vld, cmd_rdy, awvalid}, 3'b100);
            chk("t4_hold_data", rsp_data, 32'hCAFEF00D);
            tick();
        end
        cmd_vld = 1'b0;
        release_rsp();
        chk("t4_released", {rsp_vld, cmd_rdy, awvalid}, 3'b010);
        chk("t4_no_write", aw_hs - aw0, 0);
        $display("t4 read 0x00C held 10 cycles data=0x%08h", rsp_data);

        // 5: reset while waiting in WR_B
        b_hold = 1;
        issue(1'b1, 12'h010, 32'h5A5A5A5A, 4'hF);
        tick(); tick();
        chk("t5_in_wr_b", {bready, awvalid, wvalid}, 3'b100);
        rst = 1'b1;
        tick();
        chk("t5_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("t5_rdy_rsp", {cmd_rdy, rsp_vld, rsp_resp}, 4'b1000);
        chk("t5_regs", {awaddr, rsp_data}, 44'h0);
        rst = 1'b0; b_hold = 0;
        tick(); tick(); tick();
        chk("t5_no_rsp", {rsp_vld, cmd_rdy}, 2'b01);
        $display("t5 reset in WR_B cmd_rdy=%0d rsp_vld=%0d", cmd_rdy, rsp_vld);

        // recovery read after reset
        sl_rdata = 32'h55AA00FF; sl_rresp = 2'b01;
        issue(1'b0, 12'hFFC, 32'h0, 4'h0);
        wait_rsp(1, lat);
        chk("t5b_latency", lat, 4);
        chk("t5b_data_resp", {rsp_data, rsp_resp}, {32'h55AA00FF, 2'b01});
        release_rsp();
        sl_rresp = 2'b00;
        $display("t5b read 0xFFC latency=%0d data=0x%08h", lat, rsp_data);

`ifdef AXIL_TIMEOUT_EN
        // 6: responder never raises arready
        mon_en = 0; ar_never = 1;
        issue(1'b0, 12'h020, 32'h0, 4'h0);
        for (int i = 1; i < 16; i++) tick();
        chk("t6_ar_held", {arvalid, rsp_vld}, 2'b10);
        tick();
        chk("t6_abort", {arvalid, rready, rsp_vld, rsp_tout}, 4'b0011);
        chk("t6_resp", {rsp_resp, rsp_data}, {2'b10, 32'h0});
        release_rsp();
        ar_never = 0;
        tick(); tick();
        mon_en = 1;
        $display("t6 timeout read 0x020 tout=%0d", 1);
`endif

        tick();
        chk("valid_stability", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
